stacker_game_ctrl: RTL and testbench

//  Parametrised stacker-game controller. A lit segment bounces across a COLS-wide row;
//  a button press drops it onto the row below, and only the columns overlapping that
//  row survive. Play climbs ROWS rows, speeding up on each row, and ends in WIN or LOSE.

---
 rtl/stacker_pkg.sv | 26 ++
 rtl/stacker_game_ctrl_btn_rise_detect.sv | 24 ++
 rtl/stacker_game_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_stacker_game_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stacker_pkg.sv
// Shared definitions for the stacker game controller.
// Holds the FSM state encoding, the bounce direction constants and a
// constant-evaluable clog2 used to size the row and score ports.
package stacker_pkg;

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_TRACE  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_e;

  // RIGHT moves the segment toward bit 0, LEFT toward bit COLS-1.
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/stacker_game_ctrl_btn_rise_detect.sv
// Purpose: turns the level button into a single-cycle press on its rising edge.
// Latency: combinational press, valid in the same cycle btn first goes high.
// Backpressure: none; a held button yields exactly one press.
// Ports: updateClk/reset (async, active-high), btn (level in), press (pulse out).
module btn_rise_detect (
  input  logic updateClk,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic btn_q;
  logic btn_d;

  always_comb btn_d = btn;

  always_ff @(posedge updateClk or posedge reset) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn_d;
  end

  assign press = btn & ~btn_q;

endmodule

// File: rtl/stacker_game_ctrl.sv
// Purpose: stacker game FSM - bounce a segment, drop it on press, keep the overlap.
// Latency: all outputs registered; a display write appears one cycle after its cause.
// Backpressure: none; the display buffer must accept writeStrobe every cycle.
// Ports: updateClk, reset (async, active-high), btn; val/rowIndex/writeStrobe to the
//        row buffer; win/lose level flags; score = rows stacked this game.
module stacker_game_ctrl
  import stacker_pkg::*;
#(
  parameter int COLS         = 8,
  parameter int ROWS         = 8,
  parameter int INIT_LEN     = 3,
  parameter int START_PERIOD = 16,
  parameter int PERIOD_STEP  = 2,
  parameter int MIN_PERIOD   = 2
) (
  input  logic                   updateClk,
  input  logic                   reset,
  input  logic                   btn,
  output logic [COLS-1:0]        val,
  output logic [clog2(ROWS)-1:0] rowIndex,
  output logic                   writeStrobe,
  output logic                   win,
  output logic                   lose,
  output logic [clog2(ROWS):0]   score
);

  localparam int RW = clog2(ROWS);
  localparam int SW = RW + 1;
  localparam int PW = clog2(START_PERIOD + 1);
  localparam logic [COLS-1:0] SEG_INIT = {COLS{1'b1}} << (COLS - INIT_LEN);
  localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

  logic press;

  btn_rise_detect u_btn (
    .updateClk (updateClk),
    .reset     (reset),
    .btn       (btn),
    .press     (press)
  );

  state_e          state_q,    state_d;
  logic            clr_act_q,  clr_act_d;
  logic [RW-1:0]   clr_idx_q,  clr_idx_d;
  logic [COLS-1:0] cur_q,      cur_d;
  logic [COLS-1:0] prev_q,     prev_d;
  logic [COLS-1:0] landed_q,   landed_d;
  logic            dir_q,      dir_d;
  logic [PW-1:0]   period_q,   period_d;
  logic [PW-1:0]   move_cnt_q, move_cnt_d;
  logic [COLS-1:0] val_q,      val_d;
  logic [RW-1:0]   row_q,      row_d;
  logic            strobe_q,   strobe_d;
  logic            win_q,      win_d;
  logic            lose_q,     lose_d;
  logic [SW-1:0]   score_q,    score_d;

  logic [COLS-1:0] shifted;
  logic            dir_next;
  int              per_dec;

  always_comb begin
    state_d    = state_q;
    clr_act_d  = clr_act_q;
    clr_idx_d  = clr_idx_q;
    cur_d      = cur_q;
    prev_d     = prev_q;
    landed_d   = landed_q;
    dir_d      = dir_q;
    period_d   = period_q;
    move_cnt_d = move_cnt_q;
    val_d      = val_q;
    row_d      = row_q;
    strobe_d   = 1'b0;
    win_d      = win_q;
    lose_d     = lose_q;
    score_d    = score_q;

    // Next segment position; an edge cell flips direction and reflects in the same tick.
    dir_next = dir_q;
    if (dir_q == DIR_RIGHT) begin
      if (cur_q[0]) begin
        dir_next = DIR_LEFT;
        shifted  = cur_q << 1;
      end else begin
        shifted  = cur_q >> 1;
      end
    end else begin
      if (cur_q[COLS-1]) begin
        dir_next = DIR_RIGHT;
        shifted  = cur_q >> 1;
      end else begin
        shifted  = cur_q << 1;
      end
    end

    // Saturating speed-up, computed signed so the step cannot wrap below the floor.
    per_dec = int'(period_q) - PERIOD_STEP;
    if (per_dec < MIN_PERIOD) per_dec = MIN_PERIOD;

    case (state_q)
      ST_INIT: begin
        win_d  = 1'b0;
        lose_d = 1'b0;
        if (clr_act_q) begin
          strobe_d  = 1'b1;
          val_d     = '0;
          row_d     = clr_idx_q;
          clr_idx_d = clr_idx_q + RW'(1);
          if (clr_idx_q == LAST_ROW) begin
            clr_act_d = 1'b0;
            clr_idx_d = '0;
          end
        end else begin
          // Game setup is reapplied every idle cycle, so it is ready whenever the press lands.
          row_d      = '0;
          cur_d      = SEG_INIT;
          prev_d     = '1;
          score_d    = '0;
          period_d   = PW'(START_PERIOD);
          dir_d      = DIR_RIGHT;
          move_cnt_d = '0;
          if (press) begin
            state_d  = ST_TRACE;
            strobe_d = 1'b1;
            val_d    = SEG_INIT;
          end
        end
      end

      ST_TRACE: begin
        if (press) begin
          // A press beats a coinciding shift tick.
          landed_d = cur_q & prev_q;
          strobe_d = 1'b1;
          val_d    = cur_q & prev_q;
          state_d  = ST_CHECK;
        end else if (move_cnt_q == period_q - PW'(1)) begin
          move_cnt_d = '0;
          cur_d      = shifted;
          dir_d      = dir_next;
          strobe_d   = 1'b1;
          val_d      = shifted;
        end else begin
          move_cnt_d = move_cnt_q + PW'(1);
        end
      end

      ST_CHECK: begin
        if (landed_q == '0) begin
          state_d = ST_LOSE;
          lose_d  = 1'b1;
        end else begin
          score_d = score_q + SW'(1);
          if (row_q == LAST_ROW) begin
            state_d = ST_WIN;
            win_d   = 1'b1;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end

      ST_UPDATE: begin
        prev_d     = landed_q;
        cur_d      = landed_q;
        row_d      = row_q + RW'(1);
        move_cnt_d = '0;
        period_d   = PW'(per_dec);
        strobe_d   = 1'b1;
        val_d      = landed_q;
        state_d    = ST_TRACE;
      end

      ST_WIN, ST_LOSE: begin
        if (press) begin
          state_d   = ST_INIT;
          clr_act_d = 1'b1;
          clr_idx_d = '0;
          win_d     = 1'b0;
          lose_d    = 1'b0;
        end
      end

      default: begin
        state_d   = ST_INIT;
        clr_act_d = 1'b1;
        clr_idx_d = '0;
        win_d     = 1'b0;
        lose_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge updateClk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      clr_act_q  <= 1'b1;
      clr_idx_q  <= '0;
      cur_q      <= SEG_INIT;
      prev_q     <= '1;
      landed_q   <= '0;
      dir_q      <= DIR_RIGHT;
      period_q   <= PW'(START_PERIOD);
      move_cnt_q <= '0;
      val_q      <= '0;
      row_q      <= '0;
      strobe_q   <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
      score_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_act_q  <= clr_act_d;
      clr_idx_q  <= clr_idx_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      landed_q   <= landed_d;
      dir_q      <= dir_d;
      period_q   <= period_d;
      move_cnt_q <= move_cnt_d;
      val_q      <= val_d;
      row_q      <= row_d;
      strobe_q   <= strobe_d;
      win_q      <= win_d;
      lose_q     <= lose_d;
      score_q    <= score_d;
    end
  end

  assign val         = val_q;
  assign rowIndex    = row_q;
  assign writeStrobe = strobe_q;
  assign win         = win_q;
  assign lose        = lose_q;
  assign score       = score_q;

endmodule

// File: tb/tb_stacker_game_ctrl.sv
// Directed bench for stacker_game_ctrl with default parameters (8x8, len 3, period 16).
module tb_stacker_game_ctrl;

  logic       updateClk;
  logic       reset;
  logic       btn;
  logic [7:0] val;
  logic [2:0] rowIndex;
  logic       writeStrobe;
  logic       win;
  logic       lose;
  logic [3:0] score;

  int total = 0;
  int bad   = 0;

  stacker_game_ctrl dut (
    .updateClk   (updateClk),
    .reset       (reset),
    .btn         (btn),
    .val         (val),
    .rowIndex    (rowIndex),
    .writeStrobe (writeStrobe),
    .win         (win),
    .lose        (lose),
    .score       (score)
  );

  initial updateClk = 1'b0;
  always #5 updateClk = ~updateClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge updateClk);
    #1;
  endtask

  // Rising edge on btn, released right after the edge that samples it.
  task automatic press_now();
    btn = 1'b1;
    step();
    btn = 1'b0;
  endtask

  task automatic clear_check(input string tag);
    for (int i = 0; i < 8; i++) begin
      step();
      chk({tag, "_clr_stb"}, writeStrobe, 1);
      chk({tag, "_clr_row"}, rowIndex, i);
      chk({tag, "_clr_val"}, val, 0);
    end
    step();
    chk({tag, "_clr_done_stb"}, writeStrobe, 0);
    chk({tag, "_clr_done_row"}, rowIndex, 0);
  endtask

  // One shift period: quiet for p-1 cycles, then a strobe carrying the shifted row.
  task automatic tick(input int p, input int v, input int r, input string tag);
    repeat (p - 1) step();
    chk({tag, "_quiet"}, writeStrobe, 0);
    step();
    chk({tag, "_stb"}, writeStrobe, 1);
    chk({tag, "_val"}, val, v);
    chk({tag, "_row"}, rowIndex, r);
  endtask

  // Perfect drop on row r (cur == prev == v), ending on the next row's first strobe.
  task automatic stack_row(input int r, input int v);
    step();
    press_now();
    chk("stack_chk_stb", writeStrobe, 1);
    chk("stack_chk_val", val, v);
    chk("stack_chk_row", rowIndex, r);
    step();
    chk("stack_score", score, r + 1);
    chk("stack_upd_stb", writeStrobe, 0);
    step();
    chk("stack_next_stb", writeStrobe, 1);
    chk("stack_next_row", rowIndex, r + 1);
    chk("stack_next_val", val, v);
  endtask

  int seq1 [10] = '{8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h70, 8'hE0};

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    #2;
    chk("rst_stb", writeStrobe, 0);
    chk("rst_val", val, 0);
    chk("rst_row", rowIndex, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_score", score, 0);
    step();
    step();
    reset = 1'b0;

    // Clear phase then idle.
    clear_check("boot");
    repeat (5) step();
    chk("idle_stb", writeStrobe, 0);
    chk("idle_win", win, 0);
    chk("idle_lose", lose, 0);
    chk("idle_score", score, 0);

    // Game 1: start with a held button, watch the bounce.
    btn = 1'b1;
    step();
    chk("g1_start_stb", writeStrobe, 1);
    chk("g1_start_val", val, 8'hE0);
    chk("g1_start_row", rowIndex, 0);
    for (int k = 0; k < 10; k++) begin
      tick(16, seq1[k], 0, "g1_r0_tick");
      if (k == 2) btn = 1'b0;
    end

    // Drop at E0 over an all-ones floor.
    press_now();
    chk("g1_r0_drop_stb", writeStrobe, 1);
    chk("g1_r0_drop_val", val, 8'hE0);
    chk("g1_r0_drop_row", rowIndex, 0);
    chk("g1_r0_drop_score", score, 0);
    step();
    chk("g1_r0_score", score, 1);
    step();
    chk("g1_r1_start_val", val, 8'hE0);
    chk("g1_r1_start_row", rowIndex, 1);

    // Row 1 at period 14: bounce off the left edge, then 38 over E0 leaves 20.
    tick(14, 8'h70, 1, "g1_r1_tick");
    tick(14, 8'h38, 1, "g1_r1_tick");
    press_now();
    chk("g1_r1_drop_val", val, 8'h20);
    chk("g1_r1_drop_row", rowIndex, 1);
    step();
    chk("g1_r1_score", score, 2);
    step();
    chk("g1_r2_start_val", val, 8'h20);
    chk("g1_r2_start_row", rowIndex, 2);

    // Row 2 at period 12, single cell moves off the overlap.
    tick(12, 8'h10, 2, "g1_r2_tick");
    press_now();
    chk("g1_r2_drop_stb", writeStrobe, 1);
    chk("g1_r2_drop_val", val, 0);
    chk("g1_r2_drop_row", rowIndex, 2);
    step();
    chk("g1_lose", lose, 1);
    chk("g1_lose_win", win, 0);
    chk("g1_lose_score", score, 2);
    chk("g1_lose_stb", writeStrobe, 0);
    repeat (5) step();
    chk("g1_lose_hold", lose, 1);
    chk("g1_lose_hold_stb", writeStrobe, 0);
    chk("g1_lose_hold_score", score, 2);

    // Press in LOSE restarts the clear; a press during the clear is ignored.
    press_now();
    chk("g1_restart_lose", lose, 0);
    chk("g1_restart_stb", writeStrobe, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("g1_clr_stb", writeStrobe, 1);
      chk("g1_clr_row", rowIndex, i);
      if (i == 2) btn = 1'b1;
      if (i == 4) btn = 1'b0;
    end
    repeat (20) step();
    chk("g1_clr_press_ignored", writeStrobe, 0);
    chk("g1_clr_score", score, 0);

    // Game 2: perfect stacking to a win.
    press_now();
    chk("g2_start_val", val, 8'hE0);
    chk("g2_start_row", rowIndex, 0);
    for (int r = 0; r < 7; r++) stack_row(r, 8'hE0);
    // Row 7 runs at the floor period of 2.
    for (int k = 0; k < 10; k++) tick(2, seq1[k], 7, "g2_r7_tick");
    press_now();
    chk("g2_r7_drop_val", val, 8'hE0);
    chk("g2_r7_drop_row", rowIndex, 7);
    step();
    chk("g2_win", win, 1);
    chk("g2_win_lose", lose, 0);
    chk("g2_win_score", score, 8);
    chk("g2_win_stb", writeStrobe, 0);
    repeat (4) step();
    chk("g2_win_hold", win, 1);
    chk("g2_win_hold_score", score, 8);
    press_now();
    chk("g2_restart_win", win, 0);
    clear_check("g2");

    // Game 3: reset in the middle of row 3.
    press_now();
    chk("g3_start_val", val, 8'hE0);
    for (int r = 0; r < 3; r++) stack_row(r, 8'hE0);
    repeat (3) step();
    chk("g3_pre_rst_score", score, 3);
    chk("g3_pre_rst_row", rowIndex, 3);
    reset = 1'b1;
    #1;
    chk("g3_rst_stb", writeStrobe, 0);
    chk("g3_rst_val", val, 0);
    chk("g3_rst_row", rowIndex, 0);
    chk("g3_rst_score", score, 0);
    chk("g3_rst_win", win, 0);
    chk("g3_rst_lose", lose, 0);
    step();
    reset = 1'b0;
    clear_check("g3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
